// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ==== mips_ctrl_pkg -- shared opcode, state and mux encodings for the MIPS control path ====
// ==== rev 1.0 ====
package mips_ctrl_pkg;

  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_DIV  = 6'b101111;
  localparam logic [5:0] OP_MULT = 6'b101000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    MULDIV   = 4'd11,
    WB_HILO  = 4'd12,
    ILLEGAL  = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_t;

  function automatic logic is_r_class(input logic [5:0] op);
    case (op)
      OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic state_t decode_target(input logic [5:0] op);
    if (is_r_class(op)) return EXEC_R;
    case (op)
      OP_ADDI:          return EXEC_I;
      OP_LW, OP_SW:     return MEM_ADDR;
      OP_BEQ:           return BRANCH;
      OP_J:             return JUMP;
      OP_MULT, OP_DIV:  return MULDIV;
      OP_MFHI, OP_MFLO: return WB_HILO;
      default:          return ILLEGAL;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_wait_counter.sv
`default_nettype none
// ==== muldiv_wait_counter -- countdown of remaining mult/div busy cycles ====
// ==== rev 1.0 ====
module muldiv_wait_counter #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done,
  output logic first
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && !done) begin
      count <= count - 1'b1;
    end
  end

  assign done  = (count == '0);
  assign first = (count == LOAD_VAL);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ==== multicycle_control -- multi-cycle MIPS main control FSM with memory/mult-div stalls ====
// ==== rev 1.0 ====
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int OPC_W         = 6,
  parameter int ALUOP_W       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dest,
  output logic               mem_to_reg,
  output logic               hilo_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               reg_write,
  output logic               muldiv_start,
  output logic               illegal_op,
  output logic [3:0]         state
);

  state_t cur_state;
  state_t next_state;
  logic   wb_to_rd;
  logic   cnt_done;
  logic   cnt_first;

  muldiv_wait_counter #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (cur_state == DECODE && next_state == MULDIV),
    .dec  (cur_state == MULDIV),
    .done (cnt_done),
    .first(cnt_first)
  );

  // WB_ALU is shared by R-type and addi; remember which register field to write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= FETCH;
      wb_to_rd  <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (cur_state == DECODE) wb_to_rd <= is_r_class(opcode);
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      FETCH:    if (mem_ready) next_state = DECODE;
      DECODE:   next_state = decode_target(opcode);
      EXEC_R:   next_state = WB_ALU;
      EXEC_I:   next_state = WB_ALU;
      MEM_ADDR: next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) next_state = WB_MEM;
      MEM_WR:   if (mem_ready) next_state = FETCH;
      MULDIV:   if (cnt_done) next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dest      = 1'b0;
    mem_to_reg    = 1'b0;
    hilo_to_reg   = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_W'(ALU_ADD);
    pc_source     = PCSRC_ALU;
    reg_write     = 1'b0;
    muldiv_start  = 1'b0;
    illegal_op    = 1'b0;
    if (!rst) begin
      case (cur_state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE:   alu_src_b = SRCB_IMM_SH2;
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_W'(ALU_FUNCT);
        end
        EXEC_I, MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          reg_dest  = wb_to_rd;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_W'(ALU_SUB);
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        MULDIV: begin
          alu_src_a    = 1'b1;
          alu_op       = ALUOP_W'(ALU_FUNCT);
          muldiv_start = cnt_first;
        end
        WB_HILO: begin
          reg_write   = 1'b1;
          hilo_to_reg = 1'b1;
          reg_dest    = 1'b1;
        end
        ILLEGAL:  illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ==== tb_multicycle_control -- directed-vector bench for the multi-cycle control FSM ====
// ==== rev 1.0 ====
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam logic [3:0] S_F   = 4'd0,  S_D   = 4'd1,  S_ER  = 4'd2,  S_EI  = 4'd3;
  localparam logic [3:0] S_MA  = 4'd4,  S_MR  = 4'd5,  S_MW  = 4'd6,  S_WBA = 4'd7;
  localparam logic [3:0] S_WBM = 4'd8,  S_BR  = 4'd9,  S_J   = 4'd10, S_MD  = 4'd11;
  localparam logic [3:0] S_WBH = 4'd12, S_IL  = 4'd13;

  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write}_{ir_write,reg_dest,mem_to_reg,hilo_to_reg,alu_src_a}_
  // {alu_src_b}_{alu_op}_{pc_source}_{reg_write,muldiv_start,illegal_op}
  localparam logic [18:0] V_ZERO  = 19'b00000_00000_00_00_00_000;
  localparam logic [18:0] V_FR    = 19'b10010_10000_01_00_00_000;
  localparam logic [18:0] V_FN    = 19'b00010_00000_01_00_00_000;
  localparam logic [18:0] V_DEC   = 19'b00000_00000_11_00_00_000;
  localparam logic [18:0] V_EXR   = 19'b00000_00001_00_10_00_000;
  localparam logic [18:0] V_EXI   = 19'b00000_00001_10_00_00_000;
  localparam logic [18:0] V_WBARD = 19'b00000_01000_00_00_00_100;
  localparam logic [18:0] V_WBART = 19'b00000_00000_00_00_00_100;
  localparam logic [18:0] V_MRD   = 19'b00110_00000_00_00_00_000;
  localparam logic [18:0] V_WBM   = 19'b00000_00100_00_00_00_100;
  localparam logic [18:0] V_MWR   = 19'b00101_00000_00_00_00_000;
  localparam logic [18:0] V_BR    = 19'b01000_00001_00_01_01_000;
  localparam logic [18:0] V_JMP   = 19'b10000_00000_00_00_10_000;
  localparam logic [18:0] V_MD1   = 19'b00000_00001_00_10_00_010;
  localparam logic [18:0] V_MDN   = 19'b00000_00001_00_10_00_000;
  localparam logic [18:0] V_WBH   = 19'b00000_01010_00_00_00_100;
  localparam logic [18:0] V_ILL   = 19'b00000_00000_00_00_00_001;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode;
  logic mem_ready;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic reg_dest, mem_to_reg, hilo_to_reg, alu_src_a, reg_write, muldiv_start, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [18:0] ctl;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                ir_write, reg_dest, mem_to_reg, hilo_to_reg, alu_src_a,
                alu_src_b, alu_op, pc_source, reg_write, muldiv_start, illegal_op};

  multicycle_control #(.MULDIV_CYCLES(4), .OPC_W(6), .ALUOP_W(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dest(reg_dest), .mem_to_reg(mem_to_reg), .hilo_to_reg(hilo_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .reg_write(reg_write), .muldiv_start(muldiv_start),
    .illegal_op(illegal_op), .state(state)
  );

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b100000;
    @(posedge clk); #1;
    checks++; if (state !== S_F) begin failures++; $display("FAIL reset state got=%0d exp=%0d", state, S_F); end
    checks++; if (ctl !== V_ZERO) begin failures++; $display("FAIL reset outputs got=%b exp=%b", ctl, V_ZERO); end
    @(posedge clk); #1;
    checks++; if (ctl !== V_ZERO) begin failures++; $display("FAIL reset hold outputs got=%b exp=%b", ctl, V_ZERO); end
    rst = 1'b0; #1;
    checks++; if (ctl !== V_FR) begin failures++; $display("FAIL reset release fetch got=%b exp=%b", ctl, V_FR); end
    mem_ready = 1'b0; #1;
    checks++; if (ctl !== V_FN) begin failures++; $display("FAIL fetch stall outputs got=%b exp=%b", ctl, V_FN); end
    @(posedge clk); #1;
    checks++; if (state !== S_F) begin failures++; $display("FAIL fetch stall state got=%0d exp=%0d", state, S_F); end
  endtask

  task automatic test_add();
    logic [3:0] es [4] = '{S_F, S_D, S_ER, S_WBA};
    logic [18:0] ec [4] = '{V_FR, V_DEC, V_EXR, V_WBARD};
    opcode = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      checks++; if (state !== es[i]) begin failures++; $display("FAIL add c%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin failures++; $display("FAIL add c%0d ctl got=%b exp=%b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== S_F) begin failures++; $display("FAIL add return state got=%0d exp=%0d", state, S_F); end
  endtask

  task automatic test_addi();
    logic [3:0] es [4] = '{S_F, S_D, S_EI, S_WBA};
    logic [18:0] ec [4] = '{V_FR, V_DEC, V_EXI, V_WBART};
    opcode = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      checks++; if (state !== es[i]) begin failures++; $display("FAIL addi c%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin failures++; $display("FAIL addi c%0d ctl got=%b exp=%b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== S_F) begin failures++; $display("FAIL addi return state got=%0d exp=%0d", state, S_F); end
  endtask

  task automatic test_lw_wait();
    logic [3:0] es [7] = '{S_F, S_D, S_MA, S_MR, S_MR, S_MR, S_WBM};
    logic [18:0] ec [7] = '{V_FR, V_DEC, V_EXI, V_MRD, V_MRD, V_MRD, V_WBM};
    logic rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i]; #1;
      checks++; if (state !== es[i]) begin failures++; $display("FAIL lw c%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin failures++; $display("FAIL lw c%0d ctl got=%b exp=%b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== S_F) begin failures++; $display("FAIL lw return state got=%0d exp=%0d", state, S_F); end
  endtask

  task automatic test_sw_fetch_wait();
    logic [3:0] es [5] = '{S_F, S_F, S_D, S_MA, S_MW};
    logic [18:0] ec [5] = '{V_FN, V_FR, V_DEC, V_EXI, V_MWR};
    logic rdy [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i]; #1;
      checks++; if (state !== es[i]) begin failures++; $display("FAIL sw c%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin failures++; $display("FAIL sw c%0d ctl got=%b exp=%b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== S_F) begin failures++; $display("FAIL sw return state got=%0d exp=%0d", state, S_F); end
  endtask

  task automatic test_mult();
    logic [3:0] es [6] = '{S_F, S_D, S_MD, S_MD, S_MD, S_MD};
    logic [18:0] ec [6] = '{V_FR, V_DEC, V_MD1, V_MDN, V_MDN, V_MDN};
    opcode = 6'b101000;
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i == 0); #1;
      checks++; if (state !== es[i]) begin failures++; $display("FAIL mult c%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin failures++; $display("FAIL mult c%0d ctl got=%b exp=%b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== S_F) begin failures++; $display("FAIL mult return state got=%0d exp=%0d", state, S_F); end
  endtask

  task automatic test_beq_j();
    logic [5:0] op [6] = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010};
    logic [3:0] es [6] = '{S_F, S_D, S_BR, S_F, S_D, S_J};
    logic [18:0] ec [6] = '{V_FR, V_DEC, V_BR, V_FR, V_DEC, V_JMP};
    for (int i = 0; i < 6; i++) begin
      opcode = op[i]; mem_ready = 1'b1; #1;
      checks++; if (state !== es[i]) begin failures++; $display("FAIL beq_j c%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin failures++; $display("FAIL beq_j c%0d ctl got=%b exp=%b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== S_F) begin failures++; $display("FAIL beq_j return state got=%0d exp=%0d", state, S_F); end
  endtask

  task automatic test_mfhi_illegal();
    logic [5:0] op [6] = '{6'b010000, 6'b010000, 6'b010000, 6'b111111, 6'b111111, 6'b111111};
    logic [3:0] es [6] = '{S_F, S_D, S_WBH, S_F, S_D, S_IL};
    logic [18:0] ec [6] = '{V_FR, V_DEC, V_WBH, V_FR, V_DEC, V_ILL};
    for (int i = 0; i < 6; i++) begin
      opcode = op[i]; mem_ready = 1'b1; #1;
      checks++; if (state !== es[i]) begin failures++; $display("FAIL hilo_ill c%0d state got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin failures++; $display("FAIL hilo_ill c%0d ctl got=%b exp=%b", i, ctl, ec[i]); end
      @(posedge clk); #1;
    end
    checks++; if (state !== S_F) begin failures++; $display("FAIL hilo_ill return state got=%0d exp=%0d", state, S_F); end
  endtask

  // Abort an instruction at its fourth cycle (MULDIV with counter=2, or MEM_WR waiting).
  task automatic test_rst_abort(input logic [5:0] op, input logic [3:0] s3, input logic [3:0] s4,
                                input logic [18:0] c3, input logic [18:0] c4);
    logic [3:0] es [4] = '{S_F, S_D, s3, s4};
    logic [18:0] ec [4] = '{V_FR, V_DEC, c3, c4};
    opcode = op;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0); #1;
      checks++; if (state !== es[i]) begin failures++; $display("FAIL abort%0h c%0d state got=%0d exp=%0d", op, i, state, es[i]); end
      checks++; if (ctl !== ec[i]) begin failures++; $display("FAIL abort%0h c%0d ctl got=%b exp=%b", op, i, ctl, ec[i]); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    rst = 1'b1; #1;
    checks++; if (ctl !== V_ZERO) begin failures++; $display("FAIL abort%0h rst outputs got=%b exp=%b", op, ctl, V_ZERO); end
    @(posedge clk); #1;
    checks++; if (state !== S_F) begin failures++; $display("FAIL abort%0h rst state got=%0d exp=%0d", op, state, S_F); end
    checks++; if (ctl !== V_ZERO) begin failures++; $display("FAIL abort%0h rst hold got=%b exp=%b", op, ctl, V_ZERO); end
    rst = 1'b0; mem_ready = 1'b0; #1;
    checks++; if (ctl !== V_FN) begin failures++; $display("FAIL abort%0h refetch got=%b exp=%b", op, ctl, V_FN); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_lw_wait();
    test_sw_fetch_wait();
    test_mult();
    test_beq_j();
    test_mfhi_illegal();
    test_rst_abort(6'b101111, S_MD, S_MD, V_MD1, V_MDN);
    test_rst_abort(6'b101011, S_MA, S_MW, V_EXI, V_MWR);
    test_mult();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
